// File: rtl/fetch_sequencer_if.sv
// Fetch-path bundle between the PC sequencer (slave) and the decode/instruction unit (master).
interface fetch_sequencer_if;
  logic [1:0]  issue_cnt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] curr_pc0;
  logic [31:0] curr_pc1;
  logic [31:0] curr_pc2;
  logic [2:0]  slot_valid;
  logic [1:0]  fetch_state;

  modport master (
    output issue_cnt, redirect_valid, redirect_target, halt_req,
    input  curr_pc0, curr_pc1, curr_pc2, slot_valid, fetch_state
  );

  modport slave (
    input  issue_cnt, redirect_valid, redirect_target, halt_req,
    output curr_pc0, curr_pc1, curr_pc2, slot_valid, fetch_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer for the 3-wide fetch path: slot PCs, prefix valid bits, redirect bubbles, halt.
// FETCH_PERF_EN adds stall_cycles / redirect_count performance counters.
//
// state       | meaning
// ST_RUN      | fetching; PC advances by slots consumed
// ST_REDIRECT | post-redirect bubble, slots invalid
// ST_HALT     | stopped until reset
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT         = 32'h0000_0400,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.slave    fetch
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         redirect_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_HALT     = 2'b10
  } state_e;

  localparam logic [2:0] BUB_LOAD =
    (REDIRECT_BUBBLES == 0) ? 3'd0 : 3'(REDIRECT_BUBBLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  bubble_q, bubble_d;

  logic [32:0] sum0, sum1, sum2;
  logic [2:0]  valid_w;
  logic [1:0]  nvalid;
  logic [1:0]  eff;
  logic        run;

  // 33-bit sums expose the carry so wrapped slot addresses are never marked valid
  assign sum0 = {1'b0, pc_q};
  assign sum1 = {1'b0, pc_q} + 33'd4;
  assign sum2 = {1'b0, pc_q} + 33'd8;
  assign run  = (state_q == ST_RUN);

  assign valid_w[0] = run && !sum0[32] && (sum0[31:0] < PC_LIMIT);
  assign valid_w[1] = run && !sum1[32] && (sum1[31:0] < PC_LIMIT);
  assign valid_w[2] = run && !sum2[32] && (sum2[31:0] < PC_LIMIT);

  assign nvalid = {1'b0, valid_w[0]} + {1'b0, valid_w[1]} + {1'b0, valid_w[2]};
  assign eff    = (fetch.issue_cnt < nvalid) ? fetch.issue_cnt : nvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      bubble_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bubble_d = bubble_q;
    if (fetch.halt_req) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          if (fetch.redirect_valid) begin
            pc_d = {fetch.redirect_target[31:2], 2'b00};
            if (REDIRECT_BUBBLES == 0) begin
              state_d  = ST_RUN;
              bubble_d = 3'd0;
            end else begin
              state_d  = ST_REDIRECT;
              bubble_d = BUB_LOAD;
            end
          end else if (state_q == ST_REDIRECT) begin
            if (bubble_q == 3'd0) state_d = ST_RUN;
            else                  bubble_d = bubble_q - 3'd1;
          end else begin
            pc_d = pc_q + {28'd0, eff, 2'b00};
          end
        end
      endcase
    end
  end

  assign fetch.curr_pc0    = pc_q;
  assign fetch.curr_pc1    = pc_q + 32'd4;
  assign fetch.curr_pc2    = pc_q + 32'd8;
  assign fetch.slot_valid  = valid_w;
  assign fetch.fetch_state = state_q;

`ifdef FETCH_PERF_EN
  logic        stall_evt, redir_evt;
  logic [31:0] stall_q, redir_q;

  // a stall is a RUN cycle with something fetchable that decode took none of
  assign stall_evt = run && !fetch.halt_req && !fetch.redirect_valid &&
                     (valid_w != 3'b000) && (eff == 2'd0);
  assign redir_evt = (state_q != ST_HALT) && !fetch.halt_req && fetch.redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      redir_q <= 32'd0;
    end else begin
      if (stall_evt) stall_q <= stall_q + 32'd1;
      if (redir_evt) redir_q <= redir_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic vs a queue-free PC model.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_LIMIT = 32'h0000_0400;
  localparam int          BUBBLES  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  fetch_sequencer_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles, redirect_count;
`endif

  fetch_sequencer #(
    .RESET_PC(RESET_PC), .PC_LIMIT(PC_LIMIT), .REDIRECT_BUBBLES(BUBBLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch(bus.slave)
`ifdef FETCH_PERF_EN
    , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  // reference model: PC, halted flag, number of invalid bubble cycles still owed
  logic [31:0] m_pc;
  bit          m_halt;
  int          m_bub;
  longint      m_stall, m_redir;

  function automatic void model_reset();
    m_pc = RESET_PC; m_halt = 0; m_bub = 0; m_stall = 0; m_redir = 0;
  endfunction

  function automatic int model_nvalid();
    int n = 0;
    for (int k = 0; k < 3; k++) begin
      longint a = longint'(m_pc) + 4 * k;
      if (a < longint'(PC_LIMIT) && a < 64'h1_0000_0000) n++;
      else break;
    end
    return n;
  endfunction

  function automatic void model_step();
    if (m_halt) return;
    if (bus.halt_req) begin
      m_halt = 1;
    end else if (bus.redirect_valid) begin
      m_pc  = bus.redirect_target & 32'hFFFF_FFFC;
      m_bub = BUBBLES;
      m_redir = (m_redir + 1) % 64'h1_0000_0000;
    end else if (m_bub > 0) begin
      m_bub--;
    end else begin
      int n = model_nvalid();
      int e = (int'(bus.issue_cnt) < n) ? int'(bus.issue_cnt) : n;
      if (n > 0 && e == 0) m_stall = (m_stall + 1) % 64'h1_0000_0000;
      m_pc = m_pc + 32'(4 * e);
    end
  endfunction

  function automatic logic [100:0] exp_vec();
    int       n = model_nvalid();
    logic [2:0] v;
    logic [1:0] st;
    v  = (m_halt || m_bub > 0) ? 3'b000 : 3'(7 >> (3 - n));
    st = m_halt ? 2'b10 : ((m_bub > 0) ? 2'b01 : 2'b00);
    return {m_pc, m_pc + 32'd4, m_pc + 32'd8, v, st};
  endfunction

  task automatic set_in(input logic [1:0] ic, input logic rv, input logic [31:0] rt, input logic hr);
    bus.issue_cnt = ic; bus.redirect_valid = rv; bus.redirect_target = rt; bus.halt_req = hr;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [100:0] act;
    do_reset();
    act = {bus.curr_pc0, bus.curr_pc1, bus.curr_pc2, bus.slot_valid, bus.fetch_state};
    n_checks++;
    if (act !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", act, exp_vec());
    else n_pass++;
    n_checks++;
    if ({bus.curr_pc0, bus.slot_valid, bus.fetch_state} !== {RESET_PC, 3'b111, 2'b00})
      $display("FAIL reset_const: got pc=%h v=%b st=%b", bus.curr_pc0, bus.slot_valid, bus.fetch_state);
    else n_pass++;
  endtask

  task automatic test_full_issue();
    logic [100:0] act;
    set_in(2'd3, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      act = {bus.curr_pc0, bus.curr_pc1, bus.curr_pc2, bus.slot_valid, bus.fetch_state};
      n_checks++;
      if (act !== exp_vec() || bus.curr_pc0 !== 32'(12 * k) || bus.slot_valid !== 3'b111)
        $display("FAIL full_issue[%0d]: got %h expected %h", k, act, exp_vec());
      else n_pass++;
      step();
    end
  endtask

  task automatic test_partial_issue();
    logic [1:0]  ic[3]  = '{2'd1, 2'd2, 2'd0};
    logic [31:0] epc[3] = '{32'h14, 32'h1C, 32'h1C};
    set_in(2'd0, 1'b1, 32'h10, 1'b0);
    step();
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(ic[k], 1'b0, 32'd0, 1'b0);
      step();
      n_checks++;
      if (bus.curr_pc0 !== epc[k] || bus.fetch_state !== 2'b00 || bus.curr_pc0 !== m_pc)
        $display("FAIL partial_issue[%0d]: got pc=%h st=%b expected pc=%h st=00",
                 k, bus.curr_pc0, bus.fetch_state, epc[k]);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    set_in(2'd3, 1'b1, 32'h43, 1'b0);
    step();
    n_checks++;
    if ({bus.curr_pc0, bus.slot_valid, bus.fetch_state} !== {32'h40, 3'b000, 2'b01})
      $display("FAIL redirect_bubble: got pc=%h v=%b st=%b expected pc=40 v=000 st=01",
               bus.curr_pc0, bus.slot_valid, bus.fetch_state);
    else n_pass++;
    set_in(2'd3, 1'b0, 32'd0, 1'b0);
    step();
    n_checks++;
    if ({bus.curr_pc0, bus.slot_valid, bus.fetch_state} !== {32'h40, 3'b111, 2'b00})
      $display("FAIL redirect_resume: got pc=%h v=%b st=%b expected pc=40 v=111 st=00",
               bus.curr_pc0, bus.slot_valid, bus.fetch_state);
    else n_pass++;
  endtask

  task automatic test_limit();
    set_in(2'd0, 1'b1, 32'h3F8, 1'b0);
    step();
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    step();
    n_checks++;
    if ({bus.curr_pc0, bus.slot_valid} !== {32'h3F8, 3'b011})
      $display("FAIL limit_edge: got pc=%h v=%b expected pc=3f8 v=011", bus.curr_pc0, bus.slot_valid);
    else n_pass++;
    set_in(2'd3, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      set_in(2'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
      n_checks++;
      if ({bus.curr_pc0, bus.slot_valid, bus.fetch_state} !== {32'h400, 3'b000, 2'b00})
        $display("FAIL limit_hold[%0d]: got pc=%h v=%b st=%b expected pc=400 v=000 st=00",
                 k, bus.curr_pc0, bus.slot_valid, bus.fetch_state);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [100:0] act;
    int errs = 0;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] tgt;
      case ($urandom_range(0, 9))
        0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       tgt = PC_LIMIT - 32'($urandom_range(0, 16));
        default: tgt = 32'($urandom_range(0, 32'h440));
      endcase
      set_in(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), tgt, 1'b0);
      step();
      act = {bus.curr_pc0, bus.curr_pc1, bus.curr_pc2, bus.slot_valid, bus.fetch_state};
      n_checks++;
      if (act !== exp_vec()) begin
        if (errs < 10) $display("FAIL random[%0d]: got %h expected %h", k, act, exp_vec());
        errs++;
      end else n_pass++;
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if ({stall_cycles, redirect_count} !== {m_stall[31:0], m_redir[31:0]})
      $display("FAIL random_perf: got stall=%0d redir=%0d expected stall=%0d redir=%0d",
               stall_cycles, redirect_count, m_stall, m_redir);
    else n_pass++;
`endif
  endtask

  task automatic test_perf();
`ifdef FETCH_PERF_EN
    do_reset();
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    repeat (3) step();
    set_in(2'd0, 1'b1, 32'h100, 1'b0);
    step();
    set_in(2'd0, 1'b1, 32'h200, 1'b0);
    step();
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    step();
    n_checks++;
    if ({stall_cycles, redirect_count} !== {32'd3, 32'd2} || m_stall != 3 || m_redir != 2)
      $display("FAIL perf_counts: got stall=%0d redir=%0d expected stall=3 redir=2",
               stall_cycles, redirect_count);
    else n_pass++;
`endif
  endtask

  task automatic test_halt();
    logic [100:0] act;
    logic [31:0]  pc_before;
    set_in(2'd0, 1'b1, 32'h80, 1'b0);
    step();
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    step();
    pc_before = bus.curr_pc0;
    set_in(2'd3, 1'b1, 32'h200, 1'b1);
    step();
    n_checks++;
    if ({bus.curr_pc0, bus.slot_valid, bus.fetch_state} !== {pc_before, 3'b000, 2'b10})
      $display("FAIL halt_enter: got pc=%h v=%b st=%b expected pc=%h v=000 st=10",
               bus.curr_pc0, bus.slot_valid, bus.fetch_state, pc_before);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      step();
      act = {bus.curr_pc0, bus.curr_pc1, bus.curr_pc2, bus.slot_valid, bus.fetch_state};
      n_checks++;
      if (act !== exp_vec() || bus.curr_pc0 !== pc_before)
        $display("FAIL halt_hold[%0d]: got %h expected %h", k, act, exp_vec());
      else n_pass++;
    end
    // reset lands mid-cycle, well away from any clock edge
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.curr_pc0, bus.slot_valid, bus.fetch_state} !== {RESET_PC, 3'b111, 2'b00})
      $display("FAIL halt_async_reset: got pc=%h v=%b st=%b expected pc=%h v=111 st=00",
               bus.curr_pc0, bus.slot_valid, bus.fetch_state, RESET_PC);
    else n_pass++;
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(2'd2, 1'b0, 32'd0, 1'b0);
    step();
    act = {bus.curr_pc0, bus.curr_pc1, bus.curr_pc2, bus.slot_valid, bus.fetch_state};
    n_checks++;
    if (act !== exp_vec() || bus.curr_pc0 !== RESET_PC + 32'd8)
      $display("FAIL post_reset_run: got %h expected %h", act, exp_vec());
    else n_pass++;
  endtask

  initial begin
    set_in(2'd0, 1'b0, 32'd0, 1'b0);
    test_reset();
    test_full_issue();
    test_partial_issue();
    test_redirect();
    test_limit();
    test_random();
    test_perf();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
